// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/arith ops and iterative MUL/DIV
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW = $clog2(WIDTH),
   parameter bit SIGNED_SLT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             div_by_zero,
   output logic             busy
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ITER = 1'b1;
   localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];
   localparam logic [SHW:0] CNT_LAST = {{SHW{1'b0}}, 1'b1};
   logic [0:0] state;
   logic [SHW:0] cnt;
   logic [WIDTH-1:0] hi, lo, y, r1, nhi, nlo;
   logic [2*WIDTH-1:0] rl, rr;
   logic [SHW-1:0] sh;
   logic [WIDTH:0] msum, dsh, ddif;
   logic ismul, lt;
   assign in_ready = (state == IDLE);
   assign busy = (state == ITER);
   // single-cycle datapath; rotates use a doubled operand so every bit wraps
   always_comb begin
      sh = b[SHW-1:0];
      rl = {a, a} << sh;
      rr = {a, a} >> sh;
      lt = SIGNED_SLT ? ($signed(a) < $signed(b)) : (a < b);
      case (op)
         4'd0:    r1 = a + b;
         4'd4:    r1 = a << sh;
         4'd5:    r1 = a >> sh;
         4'd6:    r1 = rl[2*WIDTH-1:WIDTH];
         4'd7:    r1 = rr[WIDTH-1:0];
         4'd8:    r1 = a & b;
         4'd9:    r1 = a | b;
         4'd10:   r1 = a ^ b;
         4'd11:   r1 = ~(a | b);
         4'd12:   r1 = ~(a & b);
         4'd13:   r1 = ~(a ^ b);
         4'd14:   r1 = {{(WIDTH-1){1'b0}}, lt};
         default: r1 = a - b;
      endcase
   end
   // one shift-add (MUL) or restoring-subtract (DIV) step on {hi, lo}
   always_comb begin
      msum = {1'b0, hi} + {1'b0, y & {WIDTH{lo[0]}}};
      dsh = {hi, lo[WIDTH-1]};
      ddif = dsh - {1'b0, y};
      nhi = ismul ? msum[WIDTH:1] : (ddif[WIDTH] ? dsh[WIDTH-1:0] : ddif[WIDTH-1:0]);
      nlo = ismul ? {msum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~ddif[WIDTH]};
   end
   // control FSM, iteration registers and held result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         y <= '0;
         ismul <= 1'b0;
         out_valid <= 1'b0;
         result <= '0;
         result_hi <= '0;
         zero <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state == ITER) begin
            hi <= nhi;
            lo <= nlo;
            cnt <= cnt - CNT_LAST;
            if (cnt == CNT_LAST) begin
               state <= IDLE;
               out_valid <= 1'b1;
               result <= nlo;
               result_hi <= nhi;
               zero <= ~|nlo;
               div_by_zero <= ~ismul && ~|y;
            end
         end else if (in_valid) begin
            if (op == 4'd2 || op == 4'd3) begin
               state <= ITER;
               cnt <= CNT_INIT;
               hi <= '0;
               lo <= (op == 4'd2) ? b : a;
               y <= (op == 4'd2) ? a : b;
               ismul <= (op == 4'd2);
            end else begin
               out_valid <= 1'b1;
               result <= r1;
               result_hi <= '0;
               zero <= (op == 4'd15) ? |r1 : ~|r1;
               div_by_zero <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed table and multi-cycle sequence checks for alu_mc
module tb_alu_mc;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
   logic [3:0] op = 4'd0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic in_ready, out_valid, zero, div_by_zero, busy;
   logic [31:0] result, result_hi;
   logic s_in_ready, s_out_valid, s_zero, s_div_by_zero, s_busy;
   logic [31:0] s_result, s_result_hi;
   int checks = 0, errors = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
   } vec_t;
   vec_t tv [21];

   alu_mc #(.WIDTH(32), .SIGNED_SLT(1'b0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .result(result), .result_hi(result_hi), .zero(zero),
      .div_by_zero(div_by_zero), .busy(busy));

   alu_mc #(.WIDTH(32), .SIGNED_SLT(1'b1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op), .a(a), .b(b),
      .out_valid(s_out_valid), .result(s_result), .result_hi(s_result_hi), .zero(s_zero),
      .div_by_zero(s_div_by_zero), .busy(s_busy));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // launch MUL/DIV, optionally holding an ADD request during ITER that must only be taken at the out_valid cycle
   task automatic iter(input logic [3:0] o, input logic [31:0] x, input logic [31:0] yv,
                       input logic [31:0] er, input logic [31:0] eh, input logic ez,
                       input logic edz, input bit tail);
      int lat;
      in_valid = 1'b1; op = o; a = x; b = yv;
      tick();
      in_valid = tail; op = 4'd0; a = 32'hDEADBEEF; b = 32'h3;
      lat = 1;
      while (!out_valid && lat < 100) begin
         chk("iter_in_ready", {31'b0, in_ready}, 32'd0);
         chk("iter_busy", {31'b0, busy}, 32'd1);
         tick();
         lat++;
      end
      chk("iter_latency", 32'(lat), 32'd33);
      chk("iter_result", result, er);
      chk("iter_result_hi", result_hi, eh);
      chk("iter_zero", {31'b0, zero}, {31'b0, ez});
      chk("iter_dbz", {31'b0, div_by_zero}, {31'b0, edz});
      chk("iter_done_ready", {31'b0, in_ready}, 32'd1);
      chk("iter_done_busy", {31'b0, busy}, 32'd0);
      if (tail) begin
         tick();
         in_valid = 1'b0;
         chk("tail_valid", {31'b0, out_valid}, 32'd1);
         chk("tail_result", result, 32'hDEADBEF2);
         chk("tail_result_hi", result_hi, 32'd0);
         chk("tail_dbz", {31'b0, div_by_zero}, 32'd0);
      end
   endtask

   initial begin
      int ov;
      tv[0]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
      tv[1]  = '{4'd0,  32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
      tv[2]  = '{4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
      tv[3]  = '{4'd15, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
      tv[4]  = '{4'd15, 32'h00000005, 32'h00000003, 32'h00000002, 1'b1};
      tv[5]  = '{4'd6,  32'h80000001, 32'h00000021, 32'h00000003, 1'b0};
      tv[6]  = '{4'd7,  32'h80000001, 32'h00000021, 32'hC0000000, 1'b0};
      tv[7]  = '{4'd6,  32'h80000001, 32'h0000001F, 32'hC0000000, 1'b0};
      tv[8]  = '{4'd6,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0};
      tv[9]  = '{4'd4,  32'h80000001, 32'h00000021, 32'h00000002, 1'b0};
      tv[10] = '{4'd5,  32'h80000001, 32'h0000003F, 32'h00000001, 1'b0};
      tv[11] = '{4'd4,  32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
      tv[12] = '{4'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
      tv[13] = '{4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
      tv[14] = '{4'd10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
      tv[15] = '{4'd11, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
      tv[16] = '{4'd12, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0};
      tv[17] = '{4'd13, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0};
      tv[18] = '{4'd10, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1};
      tv[19] = '{4'd14, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0};
      tv[20] = '{4'd7,  32'h00000001, 32'h00000001, 32'h80000000, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_result_hi", result_hi, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      rst = 1'b0;

      // back-to-back single-cycle ops, one accept per clock
      for (int i = 0; i < 21; i++) begin
         in_valid = 1'b1; op = tv[i].op; a = tv[i].a; b = tv[i].b;
         tick();
         chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_result", i), result, tv[i].r);
         chk($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, tv[i].z});
         chk($sformatf("vec%0d_hi", i), result_hi, 32'd0);
      end
      in_valid = 1'b0;
      tick();
      chk("hold_valid", {31'b0, out_valid}, 32'd0);
      chk("hold_result", result, 32'h80000000);

      iter(4'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b1);
      iter(4'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
      iter(4'd2, 32'h00010000, 32'h00010000, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
      iter(4'd3, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b1, 1'b1);
      iter(4'd3, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b1, 1'b0);
      tick();
      chk("dbz_hold", {31'b0, div_by_zero}, 32'd1);
      chk("dbz_hold_hi", result_hi, 32'd9);

      // reset at cycle 10 of a DIV, with a competing request on the reset edge
      in_valid = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      chk("pre_abort_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_result_hi", result_hi, 32'd0);
      chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
      ov = 0;
      repeat (40) begin
         tick();
         if (out_valid) ov++;
      end
      chk("abort_no_out_valid", 32'(ov), 32'd0);

      in_valid = 1'b1; op = 4'd14; a = 32'hFFFFFFFF; b = 32'd1;
      tick();
      in_valid = 1'b0;
      chk("slt_u_result", result, 32'd0);
      chk("slt_u_zero", {31'b0, zero}, 32'd1);
      chk("slt_s_valid", {31'b0, s_out_valid}, 32'd1);
      chk("slt_s_result", s_result, 32'd1);
      chk("slt_s_zero", {31'b0, s_zero}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU that supersedes the purely combinational datapath ALU.
- Sits in the EX stage and is generalised in data width.
- Single-cycle ops return in one clock. MUL and DIV are iterative (shift-add and restoring) with a valid/ready handshake. Both return a full high half (MUL) or remainder (DIV).
- Rotates cover all bit positions, and shift amounts are masked.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount field width; derived, do not override.
- SIGNED_SLT, 0, 1 = SLT compares two's-complement; 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  4  opcode, see Behaviour
- a  in  WIDTH  operand 1
- b  in  WIDTH  operand 2
- out_valid  out  1  one-cycle pulse; result fields valid
- result  out  WIDTH  primary result
- result_hi  out  WIDTH  MUL upper half / DIV remainder; 0 for other ops
- zero  out  1  branch flag
- div_by_zero  out  1  set with out_valid when a DIV had b == 0
- busy  out  1  iterative op in progress

Behaviour:
- Opcodes:
  - 0 ADD: a+b, wraps mod 2^WIDTH.
  - 1 SUB: a-b.
  - 2 MUL: unsigned; {result_hi, result} = a*b.
  - 3 DIV: unsigned; result = a/b, result_hi = a%b.
  - 4 SLL: a << b[SHW-1:0].
  - 5 SRL: logical right shift, same masked amount.
  - 6 ROL: rotate left by b[SHW-1:0]; every bit rotates, including MSB.
  - 7 ROR: rotate right by b[SHW-1:0].
  - 8 AND, 9 OR, 10 XOR, 11 NOR, 12 NAND, 13 XNOR: bitwise.
  - 14 SLT: result = {0..., a<b}; signedness per SIGNED_SLT.
  - 15 BNE: result = a-b.
- Upper b bits are ignored for all shifts/rotates.
- zero:
  - Op 15: zero = (result != 0).
  - All other ops: zero = (result == 0).
  - Evaluated on result only, never result_hi.
- FSM states:
  - IDLE: in_ready = 1, busy = 0.
  - ITER: in_ready = 0, busy = 1.
- Accept occurs when in_valid && in_ready at a clock edge. a, b and op are latched internally at accept, so later input changes are ignored.
- Single-cycle ops (all except 2/3):
  - Result is registered; out_valid = 1 in the cycle after accept.
  - FSM stays IDLE, so back-to-back accepts give throughput of 1 op/cycle.
- MUL/DIV:
  - FSM goes to ITER with a counter loaded to WIDTH. One iteration per cycle.
  - When the counter reaches 0: results register, out_valid pulses, FSM returns to IDLE.
  - out_valid asserts exactly WIDTH+1 cycles after accept.
  - in_ready returns to 1 in the out_valid cycle, so a new request can be accepted in that cycle.
- Divide by zero:
  - Still runs WIDTH cycles.
  - result = all ones, result_hi = a, div_by_zero = 1.
  - div_by_zero clears on the next out_valid without that condition.
- Output holding:
  - result, result_hi, zero and div_by_zero hold their last values until the next out_valid.
  - out_valid is a single-cycle pulse; there is no downstream backpressure.
- Reset:
  - All outputs 0 except in_ready = 1; state IDLE; counter 0.
  - rst asserted mid-ITER aborts the op: no out_valid is produced and the partial result is discarded.
  - rst overrides a simultaneous in_valid.
- in_valid while in ITER is ignored (not queued). The requester must hold the request until in_ready.

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF b=1 -> next cycle out_valid=1, result=0, zero=1.
- BNE a=5 b=5 -> result=0, zero=0; BNE a=5 b=3 -> result=2, zero=1.
- ROL a=0x80000001 b=0x21 (masked amount 1) -> result=0x00000003; ROR same -> 0xC0000000.
- MUL a=0xFFFFFFFF b=2 -> out_valid exactly 33 cycles after accept; result=0xFFFFFFFE, result_hi=1; in_ready=0 and busy=1 for cycles 1..32.
- DIV a=100 b=7 -> result=14, result_hi=2 after 33 cycles. DIV a=9 b=0 -> result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
- Assert rst at cycle 10 of a DIV -> no out_valid; in_ready=1 and outputs 0 after the reset edge. Then SLT a=0xFFFFFFFF b=1: SIGNED_SLT=1 gives result=1; SIGNED_SLT=0 gives result=0.
